// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Latency: 1 cycle accept-to-Out_Valid; sustains 1 beat/cycle while Out_Ready=1.
// Backpressure: In_Ready is registered and drops only when both entries are held.
// Optional statistics counters are compiled in with `define PIPE_STAGE_STATS_EN.
module pipe_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       Stall_Count,
  output logic [15:0]       Flush_Count
`endif
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;

  logic accept;
  logic emit;

  assign Out_Valid = (state_q != EMPTY);
  assign In_Ready  = in_ready_q;
  assign Occupancy = state_q;
  // Control is forced to a bubble when nothing is held; data keeps its last value.
  assign Out_Ctrl  = Out_Valid ? main_ctrl_q : '0;
  assign Out_Data  = main_data_q;

  assign accept = In_Valid & in_ready_q;
  assign emit   = Out_Valid & Out_Ready;

  // Next-state and datapath steering; the main register always holds the oldest beat.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_ctrl_d = In_Ctrl;
          main_data_d = In_Data;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_ctrl_d = In_Ctrl;
          main_data_d = In_Data;
        end else if (accept) begin
          state_d     = FULL;
          skid_ctrl_d = In_Ctrl;
          skid_data_d = In_Data;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          state_d     = ONE;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything held plus any beat accepted this cycle; an emit
    // in the same cycle has already been taken downstream.
    if (Flush) begin
      state_d     = EMPTY;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
    end
    in_ready_d = (state_d != FULL);
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;

  // Saturating counters for downstream stalls and flushes that discard beats.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Out_Valid && !Out_Ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (Flush && (state_q != EMPTY) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Counter registers cleared by reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: reset, single beat, streaming, backpressure,
// flush while full, reset mid-transfer, and the optional statistics counters.
// Inputs change 1ns after the rising edge; outputs are checked at that point.
module tb_pipe_stage;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 9;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Flush;
  logic              In_Valid;
  logic              In_Ready;
  logic [CTRL_W-1:0] In_Ctrl;
  logic [DATA_W-1:0] In_Data;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [CTRL_W-1:0] Out_Ctrl;
  logic [DATA_W-1:0] Out_Data;
  logic [1:0]        Occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]       Stall_Count;
  logic [15:0]       Flush_Count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Flush     (Flush),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Ctrl   (In_Ctrl),
    .In_Data   (In_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Ctrl  (Out_Ctrl),
    .Out_Data  (Out_Data),
    .Occupancy (Occupancy)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .Stall_Count (Stall_Count),
    .Flush_Count (Flush_Count)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    In_Valid = v;
    In_Ctrl  = c;
    In_Data  = d;
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0; Out_Ready = 1'b0;
    drive(1'b0, '0, '0);
    step(); step();
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_in_ready",  In_Ready, 0);
    chk("rst_out_ctrl",  Out_Ctrl, 0);
    chk("rst_out_data",  Out_Data, 0);
    chk("rst_occ",       Occupancy, 0);
`ifdef PIPE_STAGE_STATS_EN
    chk("rst_stall_cnt", Stall_Count, 0);
    chk("rst_flush_cnt", Flush_Count, 0);
`endif

    // First edge after reset release raises In_Ready.
    Reset = 1'b0;
    step();
    chk("post_rst_in_ready", In_Ready, 1);
    chk("post_rst_occ",      Occupancy, 0);

    // Single beat, one cycle latency.
    Out_Ready = 1'b1;
    drive(1'b1, 9'h1A5, 32'hDEADBEEF);
    step();
    chk("single_valid", Out_Valid, 1);
    chk("single_ctrl",  Out_Ctrl, 9'h1A5);
    chk("single_data",  Out_Data, 32'hDEADBEEF);
    chk("single_occ",   Occupancy, 1);
    drive(1'b0, '0, '0);
    step();
    chk("drain_valid",     Out_Valid, 0);
    chk("drain_ctrl_zero", Out_Ctrl, 0);
    chk("drain_data_hold", Out_Data, 32'hDEADBEEF);

    // Back-to-back stream of 8 beats.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CTRL_W'(i), DATA_W'(i));
      step();
      chk($sformatf("stream_data_%0d", i), Out_Data, i);
      chk($sformatf("stream_valid_%0d", i), Out_Valid, 1);
      chk($sformatf("stream_rdy_%0d", i), In_Ready, 1);
    end
    drive(1'b0, '0, '0);
    step();
    chk("stream_end_valid", Out_Valid, 0);

    // Backpressure: A, B accepted, C held upstream.
    Out_Ready = 1'b0;
    drive(1'b1, 9'h00A, 32'hA);
    step();
    chk("bp_a_occ",  Occupancy, 1);
    chk("bp_a_data", Out_Data, 32'hA);
    drive(1'b1, 9'h00B, 32'hB);
    step();
    chk("bp_b_occ",   Occupancy, 2);
    chk("bp_b_rdy",   In_Ready, 0);
    chk("bp_b_data",  Out_Data, 32'hA);
    drive(1'b1, 9'h00C, 32'hC);
    step();
    chk("bp_c_occ",   Occupancy, 2);
    chk("bp_c_rdy",   In_Ready, 0);
    chk("bp_c_data",  Out_Data, 32'hA);
    chk("bp_c_ctrl",  Out_Ctrl, 9'h00A);
    Out_Ready = 1'b1;
    step();
    chk("bp_out_b",     Out_Data, 32'hB);
    chk("bp_out_b_occ", Occupancy, 1);
    chk("bp_out_b_rdy", In_Ready, 1);
    step();
    chk("bp_out_c",       Out_Data, 32'hC);
    chk("bp_out_c_valid", Out_Valid, 1);
    drive(1'b0, '0, '0);
    step();
    chk("bp_done_valid", Out_Valid, 0);

    // Flush while FULL with a beat offered.
    Out_Ready = 1'b0;
    drive(1'b1, 9'h011, 32'h11);
    step();
    drive(1'b1, 9'h022, 32'h22);
    step();
    chk("fl_full_occ", Occupancy, 2);
    Flush = 1'b1;
    drive(1'b1, 9'h033, 32'h33);
    step();
    chk("fl_occ",   Occupancy, 0);
    chk("fl_valid", Out_Valid, 0);
    chk("fl_ctrl",  Out_Ctrl, 0);
    chk("fl_rdy",   In_Ready, 1);
    Flush = 1'b0;
    drive(1'b0, '0, '0);
    Out_Ready = 1'b1;
    step();
    chk("fl_no_ghost_valid", Out_Valid, 0);
    chk("fl_data_hold",      Out_Data, 32'h11);

    // Reset while ONE with a beat pending.
    Out_Ready = 1'b0;
    drive(1'b1, 9'h044, 32'h44);
    step();
    chk("rm_one_occ", Occupancy, 1);
    Reset = 1'b1;
    drive(1'b1, 9'h055, 32'h55);
    step();
    chk("rm_valid", Out_Valid, 0);
    chk("rm_rdy",   In_Ready, 0);
    chk("rm_ctrl",  Out_Ctrl, 0);
    chk("rm_data",  Out_Data, 0);
    chk("rm_occ",   Occupancy, 0);
    Reset = 1'b0;
    drive(1'b0, '0, '0);
    step();
    chk("rm_rel_rdy",   In_Ready, 1);
    chk("rm_rel_valid", Out_Valid, 0);

`ifdef PIPE_STAGE_STATS_EN
    // Five stalled cycles, then a flush with a held beat.
    drive(1'b1, 9'h066, 32'h66);
    step();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) step();
    chk("st_stall_5", Stall_Count, 5);
    Out_Ready = 1'b1;
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("st_stall_after", Stall_Count, 5);
    chk("st_flush_1",     Flush_Count, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 The block SHALL be a parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, a flush input and a bubble control field.
REQ-002 Parameter DATA_W, default 32: width of the datapath payload.
REQ-003 Parameter CTRL_W, default 9: width of the control payload (WB/M control bits).
REQ-004 Ports, in order:
- Clk  in  1  clock.
- Reset  in  1  reset: synchronous, active-high.
- Flush  in  1  discard all held beats.
- In_Valid  in  1  upstream beat present.
- In_Ready  out  1  stage can accept.
- In_Ctrl  in  CTRL_W  upstream control.
- In_Data  in  DATA_W  upstream payload.
- Out_Valid  out  1  downstream beat present.
- Out_Ready  in  1  downstream accepts.
- Out_Ctrl  out  CTRL_W  downstream control.
- Out_Data  out  DATA_W  downstream payload.
- Occupancy  out  2  held beats (0..2).
REQ-005 Reset is Reset: synchronous, active-high. Clock is Clk. All state SHALL update on the rising edge of Clk only.

Function
REQ-006 Accept SHALL occur when In_Valid=1 and In_Ready=1; emit SHALL occur when Out_Valid=1 and Out_Ready=1.
REQ-007 The state machine SHALL have states EMPTY, ONE and FULL, with Occupancy of 0, 1 and 2 respectively.
REQ-008 Transitions from EMPTY:
- accept -> ONE.
- otherwise stay in EMPTY.
REQ-009 Transitions from ONE:
- accept and emit -> ONE, with the main register replaced by the new beat.
- accept only -> FULL, with the new beat written to the skid register.
- emit only -> EMPTY.
REQ-010 Transitions from FULL:
- emit -> ONE, with the skid contents moved to the main register in the same edge.
- no emit -> hold both registers.
REQ-011 In_Ready SHALL be a registered output equal to 1 in EMPTY and ONE and 0 in FULL; it SHALL never depend combinationally on Out_Ready.
REQ-012 Out_Valid SHALL be 1 exactly when the state is ONE or FULL.
- Out_Ctrl/Out_Data SHALL always present the oldest held beat.
REQ-013 Latency SHALL be 1 cycle from accept to Out_Valid. Sustained throughput SHALL be 1 beat per cycle while Out_Ready=1.
REQ-014 Beats SHALL leave in acceptance order. No beat SHALL be duplicated or lost except through Flush or Reset.
REQ-015 Out_Ctrl SHALL be all-zero (bubble) whenever Out_Valid=0.
- Out_Data SHALL hold its last value while Out_Valid=0.
REQ-016 Flush=1 SHALL force the state to EMPTY at the next edge:
- an accept in the same cycle SHALL be dropped;
- an emit in the same cycle SHALL still count as delivered downstream;
- In_Ready SHALL be 1 in the following cycle.
REQ-017 Out_Valid and In_Ready SHALL remain stable while their handshake is pending.
- Out_Ctrl/Out_Data SHALL remain stable while Out_Valid=1 and Out_Ready=0.

Reset
REQ-018 While Reset=1 at an edge, the block SHALL clear to EMPTY:
- Out_Valid=0, In_Ready=0, Out_Ctrl=0, Out_Data=0, Occupancy=0;
- every statistics counter (if compiled in) = 0.
REQ-019 In_Ready SHALL rise to 1 on the first edge after Reset deasserts.
REQ-020 Reset SHALL take priority over Flush and over any handshake. Reset asserted mid-transfer SHALL discard all held beats.

Configuration
REQ-021 Macro PIPE_STAGE_STATS_EN, when defined, SHALL add the following outputs:
- Stall_Count  out  32  cycles with Out_Valid=1 and Out_Ready=0;
- Flush_Count  out  16  cycles with Flush=1 and Occupancy>0.
REQ-022 Both counters SHALL saturate at all-ones.
REQ-023 Without PIPE_STAGE_STATS_EN, neither port nor the counter logic SHALL exist. All other behaviour SHALL be identical in both builds.

Verification
REQ-024 Reset, then In_Valid=1 with Ctrl=0x1A5 and Data=0xDEADBEEF, Out_Ready=1 -> next cycle Out_Valid=1, Out_Ctrl=0x1A5, Out_Data=0xDEADBEEF, Occupancy=1.
REQ-025 Stream of 8 beats with Data=1..8 and Out_Ready held at 1 -> outputs 1..8 on consecutive cycles; In_Ready stays 1 throughout.
REQ-026 Out_Ready=0 while 3 beats (A, B, C) are offered:
- A and B are accepted, In_Ready=0, Occupancy=2, C is held upstream;
- Out_Ready=1 then yields A, B, C in order with no gap after C is accepted.
REQ-027 State FULL with Flush=1 and In_Valid=1 in the same cycle -> next cycle Occupancy=0, Out_Valid=0, Out_Ctrl=0, In_Ready=1; the offered beat never appears.
REQ-028 Reset asserted in state ONE with a pending In_Valid -> next cycle all outputs are 0; In_Ready=1 one cycle after Reset falls.
REQ-029 With PIPE_STAGE_STATS_EN, hold Out_Valid=1 and Out_Ready=0 for 5 cycles, then pulse Flush -> Stall_Count=5 and Flush_Count=1.
